// File: rtl/cva6_hpicache_refill_pkg.sv
// Shared types and sizing helpers for the HPI-cache line refill adapter.
package cva6_hpicache_refill_pkg;

  // Refill sequencing: accept line request, issue burst, gather beats, return line.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_RESP    = 2'd3
  } refill_state_e;

  // Number of bus beats that make up one cache line.
  function automatic int calc_beats(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Number of byte-offset address bits inside one cache line.
  function automatic int calc_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/cva6_hpicache_refill_skid.sv
// One-entry holding slot for a line request that arrives while a refill is busy.
module cva6_hpicache_refill_skid #(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [ID_W-1:0]   push_id,
  input  logic              pop,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [ID_W-1:0]   id
);

  logic              full_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ID_W-1:0]   id_reg;

  // Occupancy flag is reset; the payload only changes on push.
  always_ff @(posedge clk) begin
    if (srst) begin
      full_reg <= 1'b0;
    end else begin
      if (push) begin
        full_reg <= 1'b1;
        addr_reg <= push_addr;
        id_reg   <= push_id;
      end else if (pop) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign full = full_reg;
  assign addr = addr_reg;
  assign id   = id_reg;

endmodule

// File: rtl/cva6_hpicache_refill_adapter.sv
// Converts a single cache line read into a system bus burst and reassembles
// the beats into a full line. One refill outstanding at a time.
// Optional macro CVA6_HPICACHE_REFILL_SKID_EN adds a one-entry request skid so
// a new line request can be taken while a refill is in progress.
module cva6_hpicache_refill_adapter
  import cva6_hpicache_refill_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int ID_W   = 4,
  parameter int LINE_W = 512,
  parameter int BUS_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              line_req_valid_i,
  output logic              line_req_ready_o,
  input  logic [ADDR_W-1:0] line_req_addr_i,
  input  logic [ID_W-1:0]   line_req_id_i,
  output logic              line_rsp_valid_o,
  input  logic              line_rsp_ready_i,
  output logic [LINE_W-1:0] line_rsp_data_o,
  output logic [ID_W-1:0]   line_rsp_id_o,
  output logic              line_rsp_error_o,
  output logic              bus_req_valid_o,
  input  logic              bus_req_ready_i,
  output logic [ADDR_W-1:0] bus_req_addr_o,
  output logic [ID_W-1:0]   bus_req_id_o,
  output logic [7:0]        bus_req_len_o,
  input  logic              bus_rsp_valid_i,
  output logic              bus_rsp_ready_o,
  input  logic [BUS_W-1:0]  bus_rsp_data_i,
  input  logic [ID_W-1:0]   bus_rsp_id_i,
  input  logic              bus_rsp_last_i,
  input  logic              bus_rsp_error_i
);

  localparam int BEATS = calc_beats(LINE_W, BUS_W);
  localparam int OFF_W = calc_off_w(LINE_W);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = {{(ADDR_W-OFF_W){1'b0}}, {OFF_W{1'b1}}};

  refill_state_e     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [BUS_W-1:0]  beat_reg [BEATS];

  logic              line_req_hs;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ID_W-1:0]   start_id;
  logic              beat_hs;
  logic              cnt_last;
  logic              beat_end;
  logic              beat_err;

`ifdef CVA6_HPICACHE_REFILL_SKID_EN
  logic              skid_full;
  logic              skid_push;
  logic              skid_pop;
  logic [ADDR_W-1:0] skid_addr;
  logic [ID_W-1:0]   skid_id;

  // Requests are taken whenever the slot is free; in IDLE they start directly,
  // otherwise they park in the skid until the current line is returned.
  assign line_req_ready_o = !rst_i && !skid_full;
  assign line_req_hs      = line_req_valid_i && line_req_ready_o;
  assign skid_push        = line_req_hs && (state_reg != ST_IDLE);
  assign skid_pop         = skid_full && ((state_reg == ST_IDLE) ||
                                          ((state_reg == ST_RESP) && line_rsp_ready_i));
  assign start            = skid_pop || (line_req_hs && (state_reg == ST_IDLE));
  assign start_addr       = skid_full ? skid_addr : line_req_addr_i;
  assign start_id         = skid_full ? skid_id : line_req_id_i;

  cva6_hpicache_refill_skid #(
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W)
  ) u_skid (
    .clk       (clk_i),
    .srst      (rst_i),
    .push      (skid_push),
    .push_addr (line_req_addr_i),
    .push_id   (line_req_id_i),
    .pop       (skid_pop),
    .full      (skid_full),
    .addr      (skid_addr),
    .id        (skid_id)
  );
`else
  assign line_req_ready_o = !rst_i && (state_reg == ST_IDLE);
  assign line_req_hs      = line_req_valid_i && line_req_ready_o;
  assign start            = line_req_hs;
  assign start_addr       = line_req_addr_i;
  assign start_id         = line_req_id_i;
`endif

  assign bus_rsp_ready_o = !rst_i && (state_reg == ST_COLLECT);
  assign beat_hs         = bus_rsp_valid_i && bus_rsp_ready_o;
  assign cnt_last        = (cnt_reg == LAST_BEAT);
  assign beat_end        = cnt_last || bus_rsp_last_i;
  // Bad status, foreign ID, early last or missing last all poison the line.
  assign beat_err        = bus_rsp_error_i || (bus_rsp_id_i != id_reg) ||
                           (cnt_last != bus_rsp_last_i);

  // Next-state selection for the refill sequence.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (start) state_next = ST_REQ;
      ST_REQ:     if (bus_req_ready_i) state_next = ST_COLLECT;
      ST_COLLECT: if (beat_hs && beat_end) state_next = ST_RESP;
      ST_RESP:    if (line_rsp_ready_i) state_next = start ? ST_REQ : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State, beat counter and sticky error; request and beat payloads are not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        addr_reg <= start_addr & ~OFF_MASK;
        id_reg   <= start_id;
        err_reg  <= 1'b0;
      end
      if (beat_hs) begin
        beat_reg[cnt_reg] <= bus_rsp_data_i;
        err_reg           <= err_reg || beat_err;
        cnt_reg           <= beat_end ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  // Beat k lands in the k-th BUS_W slice of the line, beat 0 at the LSBs.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    assign line_rsp_data_o[gi*BUS_W +: BUS_W] = beat_reg[gi];
  end

  assign bus_req_valid_o  = !rst_i && (state_reg == ST_REQ);
  assign bus_req_addr_o   = addr_reg;
  assign bus_req_id_o     = id_reg;
  assign bus_req_len_o    = 8'(BEATS - 1);
  assign line_rsp_valid_o = !rst_i && (state_reg == ST_RESP);
  assign line_rsp_id_o    = id_reg;
  assign line_rsp_error_o = err_reg;

endmodule

// File: tb/tb_cva6_hpicache_refill_adapter.sv
// Directed bench for the line refill adapter with default parameters.
module tb_cva6_hpicache_refill_adapter;

  localparam int ADDR_W = 64;
  localparam int ID_W   = 4;
  localparam int LINE_W = 512;
  localparam int BUS_W  = 64;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              line_req_valid_i;
  logic              line_req_ready_o;
  logic [ADDR_W-1:0] line_req_addr_i;
  logic [ID_W-1:0]   line_req_id_i;
  logic              line_rsp_valid_o;
  logic              line_rsp_ready_i;
  logic [LINE_W-1:0] line_rsp_data_o;
  logic [ID_W-1:0]   line_rsp_id_o;
  logic              line_rsp_error_o;
  logic              bus_req_valid_o;
  logic              bus_req_ready_i;
  logic [ADDR_W-1:0] bus_req_addr_o;
  logic [ID_W-1:0]   bus_req_id_o;
  logic [7:0]        bus_req_len_o;
  logic              bus_rsp_valid_i;
  logic              bus_rsp_ready_o;
  logic [BUS_W-1:0]  bus_rsp_data_i;
  logic [ID_W-1:0]   bus_rsp_id_i;
  logic              bus_rsp_last_i;
  logic              bus_rsp_error_i;

  int total = 0;
  int bad   = 0;
  logic [LINE_W-1:0] exp_line;

  always #5 clk = ~clk;

  cva6_hpicache_refill_adapter #(
    .ADDR_W (ADDR_W),
    .ID_W   (ID_W),
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .line_req_valid_i (line_req_valid_i),
    .line_req_ready_o (line_req_ready_o),
    .line_req_addr_i  (line_req_addr_i),
    .line_req_id_i    (line_req_id_i),
    .line_rsp_valid_o (line_rsp_valid_o),
    .line_rsp_ready_i (line_rsp_ready_i),
    .line_rsp_data_o  (line_rsp_data_o),
    .line_rsp_id_o    (line_rsp_id_o),
    .line_rsp_error_o (line_rsp_error_o),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_req_addr_o   (bus_req_addr_o),
    .bus_req_id_o     (bus_req_id_o),
    .bus_req_len_o    (bus_req_len_o),
    .bus_rsp_valid_i  (bus_rsp_valid_i),
    .bus_rsp_ready_o  (bus_rsp_ready_o),
    .bus_rsp_data_i   (bus_rsp_data_i),
    .bus_rsp_id_i     (bus_rsp_id_i),
    .bus_rsp_last_i   (bus_rsp_last_i),
    .bus_rsp_error_i  (bus_rsp_error_i)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Present a line request for one cycle; called at a negedge.
  task automatic send_req(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id);
    chk("req_ready", line_req_ready_o, 1'b1);
    line_req_valid_i = 1'b1;
    line_req_addr_i  = a;
    line_req_id_i    = id;
    @(negedge clk);
    line_req_valid_i = 1'b0;
  endtask

  // Check the burst request, optionally stall it, then grant it.
  task automatic grant(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id, input int stall);
    logic [ADDR_W-1:0] ea;
    ea = a & ~64'h3f;
    chk("breq_valid", bus_req_valid_o, 1'b1);
    chk("breq_addr", bus_req_addr_o, ea);
    chk("breq_id", bus_req_id_o, id);
    chk("breq_len", bus_req_len_o, 8'd7);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("breq_hold_valid", bus_req_valid_o, 1'b1);
      chk("breq_hold_addr", bus_req_addr_o, ea);
      chk("breq_hold_id", bus_req_id_o, id);
      chk("breq_hold_len", bus_req_len_o, 8'd7);
`ifndef CVA6_HPICACHE_REFILL_SKID_EN
      chk("no_req_ready", line_req_ready_o, 1'b0);
`endif
    end
    bus_req_ready_i = 1'b1;
    @(negedge clk);
    bus_req_ready_i = 1'b0;
    chk("breq_drop", bus_req_valid_o, 1'b0);
  endtask

  // Feed beats k0..k1-1; beat data is seed*(k+1).
  task automatic beats(input logic [ID_W-1:0] id, input logic [63:0] seed, input int k0, input int k1,
                       input int err_beat, input int badid_beat, input int last_beat);
    logic [63:0] d;
    for (int k = k0; k < k1; k++) begin
      d = seed * 64'(k + 1);
      chk("rsp_ready", bus_rsp_ready_o, 1'b1);
      bus_rsp_valid_i = 1'b1;
      bus_rsp_data_i  = d;
      bus_rsp_id_i    = (k == badid_beat) ? id - 4'd1 : id;
      bus_rsp_last_i  = (k == last_beat);
      bus_rsp_error_i = (k == err_beat);
      exp_line[k*BUS_W +: BUS_W] = d;
      @(negedge clk);
    end
    bus_rsp_valid_i = 1'b0;
    bus_rsp_last_i  = 1'b0;
    bus_rsp_error_i = 1'b0;
  endtask

  // Check the line response, hold it one cycle, then accept it.
  task automatic take_rsp(input logic [ID_W-1:0] id, input logic exp_err);
    chk("lrsp_valid", line_rsp_valid_o, 1'b1);
    chk("lrsp_data", line_rsp_data_o, exp_line);
    chk("lrsp_id", line_rsp_id_o, id);
    chk("lrsp_err", line_rsp_error_o, exp_err);
    @(negedge clk);
    chk("lrsp_hold_valid", line_rsp_valid_o, 1'b1);
    chk("lrsp_hold_data", line_rsp_data_o, exp_line);
    chk("lrsp_hold_err", line_rsp_error_o, exp_err);
    line_rsp_ready_i = 1'b1;
    @(negedge clk);
    line_rsp_ready_i = 1'b0;
    chk("lrsp_drop", line_rsp_valid_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    line_req_valid_i = 1'b0; line_req_addr_i = '0; line_req_id_i = '0;
    line_rsp_ready_i = 1'b0; bus_req_ready_i = 1'b0;
    bus_rsp_valid_i = 1'b0; bus_rsp_data_i = '0; bus_rsp_id_i = '0;
    bus_rsp_last_i = 1'b0; bus_rsp_error_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", line_req_ready_o, 1'b0);
    chk("rst_breq_valid", bus_req_valid_o, 1'b0);
    chk("rst_lrsp_valid", line_rsp_valid_o, 1'b0);
    chk("rst_rsp_ready", bus_rsp_ready_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);

    // Clean refill, immediate grant.
    send_req(64'h8000_0047, 4'd3);
    grant(64'h8000_0047, 4'd3, 0);
    beats(4'd3, 64'h11, 0, 8, -1, -1, 7);
    chk("beat0_lsb", line_rsp_data_o[63:0], 64'h11);
    take_rsp(4'd3, 1'b0);

    // Grant stalled 5 cycles.
    send_req(64'h0000_1234_5678_9abc, 4'd9);
    grant(64'h0000_1234_5678_9abc, 4'd9, 5);
    beats(4'd9, 64'h0101_0101_0101_0101, 0, 8, -1, -1, 7);
    take_rsp(4'd9, 1'b0);

    // Error status on beat 4, then a clean refill clears it.
    send_req(64'h4000_0100, 4'd3);
    grant(64'h4000_0100, 4'd3, 0);
    beats(4'd3, 64'h1000, 0, 8, 4, -1, 7);
    take_rsp(4'd3, 1'b1);
    send_req(64'h4000_0140, 4'd4);
    grant(64'h4000_0140, 4'd4, 0);
    beats(4'd4, 64'h2000, 0, 8, -1, -1, 7);
    take_rsp(4'd4, 1'b0);

    // Early last on beat 5: remaining beats keep stale data.
    send_req(64'h5000_0000, 4'd3);
    grant(64'h5000_0000, 4'd3, 0);
    beats(4'd3, 64'h3000, 0, 6, -1, -1, 5);
    take_rsp(4'd3, 1'b1);

    // Foreign ID on one beat.
    send_req(64'h6000_0000, 4'd3);
    grant(64'h6000_0000, 4'd3, 0);
    beats(4'd3, 64'h4000, 0, 8, -1, 2, 7);
    take_rsp(4'd3, 1'b1);

    // Reset while collecting beat 3.
    send_req(64'h7000_0000, 4'd5);
    grant(64'h7000_0000, 4'd5, 0);
    beats(4'd5, 64'h21, 0, 3, -1, -1, -1);
    bus_rsp_valid_i = 1'b1;
    bus_rsp_data_i  = 64'hdead;
    bus_rsp_id_i    = 4'd5;
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_breq", bus_req_valid_o, 1'b0);
    chk("mid_rst_lrsp", line_rsp_valid_o, 1'b0);
    chk("mid_rst_rsp_ready", bus_rsp_ready_o, 1'b0);
    chk("mid_rst_req_ready", line_req_ready_o, 1'b0);
    rst_i = 1'b0;
    bus_rsp_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_lrsp", line_rsp_valid_o, 1'b0);
    send_req(64'h7000_0080, 4'd6);
    grant(64'h7000_0080, 4'd6, 0);
    beats(4'd6, 64'h1234, 0, 8, -1, -1, 7);
    take_rsp(4'd6, 1'b0);

`ifdef CVA6_HPICACHE_REFILL_SKID_EN
    // Second request parked during COLLECT, issued right after the first response.
    send_req(64'h2000, 4'd1);
    grant(64'h2000, 4'd1, 0);
    beats(4'd1, 64'h55, 0, 2, -1, -1, -1);
    send_req(64'h3080, 4'd7);
    chk("skid_busy", line_req_ready_o, 1'b0);
    beats(4'd1, 64'h55, 2, 8, -1, -1, 7);
    take_rsp(4'd1, 1'b0);
    grant(64'h3080, 4'd7, 0);
    beats(4'd7, 64'h66, 0, 8, -1, -1, 7);
    take_rsp(4'd7, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
